// File: rtl/modulo_abastecedor_rolhas_pkg.sv
// -----------------------------------------------------------------------------
// modulo_abastecedor_rolhas_pkg
// Shared definitions for the cork-tray load path: cork-count width, tray
// capacity, producer FSM state encoding and a small min helper. The tray
// buffer and the over-99 checker use the same constants.
// -----------------------------------------------------------------------------
package modulo_abastecedor_rolhas_pkg;

    localparam int CORK_W         = 7;
    localparam int TRAY_MAX_LEVEL = 99;

    typedef logic [CORK_W-1:0] cork_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_REQ    = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    function automatic cork_t min_cork(input cork_t a, input cork_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/modulo_calc_quantidade_rolhas.sv
// -----------------------------------------------------------------------------
// modulo_calc_quantidade_rolhas
// Combinational transfer-size calculator: min(REFILL_AMT, stock, room), where
// room is the free space left in the tray, saturated at 0 when the tray is at
// or above MAX_LEVEL. Also usable by display and alarm logic.
//
// Ports:
//   tray_level  in  7  current tray cork count
//   stock       in  7  warehouse stock available
//   amount      out 7  corks that may be moved now (0 = nothing to do)
// -----------------------------------------------------------------------------
module modulo_calc_quantidade_rolhas
    import modulo_abastecedor_rolhas_pkg::*;
#(
    parameter int REFILL_AMT = 20,
    parameter int MAX_LEVEL  = TRAY_MAX_LEVEL
) (
    input  logic [CORK_W-1:0] tray_level,
    input  logic [CORK_W-1:0] stock,
    output logic [CORK_W-1:0] amount
);

    cork_t room;

    always_comb begin
        // Saturate instead of wrapping when the tray is already full or over.
        if (tray_level >= cork_t'(MAX_LEVEL)) begin
            room = '0;
        end else begin
            room = cork_t'(MAX_LEVEL) - tray_level;
        end
        amount = min_cork(min_cork(cork_t'(REFILL_AMT), stock), room);
    end

endmodule

// File: rtl/modulo_abastecedor_rolhas.sv
// -----------------------------------------------------------------------------
// modulo_abastecedor_rolhas
// Producer side of the cork-tray load interface. Holds the warehouse stock
// register, decides when a refill is needed, sizes it and offers it to the
// tray with a load_req/load_ack handshake.
//
// Optional build macro: ABASTECEDOR_ACK_TIMEOUT_EN
//   Defined   -> REQ gives up after TIMEOUT_CYC cycles without ack and latches
//                fault; no new transfer starts until clr.
//   Undefined -> REQ waits for ack indefinitely; fault is tied to 0.
//
// Ports:
//   clk          in  1  system clock, rising edge
//   clr          in  1  asynchronous active-high reset
//   enable       in  1  plant running; low forces IDLE
//   tray_level   in  7  current tray cork count
//   op_req       in  1  manual refill request pulse
//   stock_load   in  1  load stock_in into the stock register (IDLE only)
//   stock_in     in  7  new warehouse stock value
//   load_ack     in  1  tray accepted load_amount
//   load_req     out 1  transfer offer valid
//   load_amount  out 7  corks offered, stable while load_req is high
//   stock_level  out 7  current stock register
//   sem_estoque  out 1  stock is empty
//   busy         out 1  FSM not in IDLE
//   fault        out 1  ack timeout latched
// -----------------------------------------------------------------------------
module modulo_abastecedor_rolhas
    import modulo_abastecedor_rolhas_pkg::*;
#(
    parameter int MIN_LEVEL   = 5,
    parameter int REFILL_AMT  = 20,
    parameter int MAX_LEVEL   = TRAY_MAX_LEVEL,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              enable,
    input  logic [CORK_W-1:0] tray_level,
    input  logic              op_req,
    input  logic              stock_load,
    input  logic [CORK_W-1:0] stock_in,
    input  logic              load_ack,
    output logic              load_req,
    output logic [CORK_W-1:0] load_amount,
    output logic [CORK_W-1:0] stock_level,
    output logic              sem_estoque,
    output logic              busy,
    output logic              fault
);

    // One counter serves both SETTLE and the REQ timeout; size it for the larger.
    localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    state_e state_q, state_d;
    cork_t  stock_q, stock_d;
    cork_t  amt_q,   amt_d;
    cnt_t   cnt_q,   cnt_d;
    cork_t  calc_amt;
    logic   trigger;
    logic   fault_int;

    modulo_calc_quantidade_rolhas #(
        .REFILL_AMT (REFILL_AMT),
        .MAX_LEVEL  (MAX_LEVEL)
    ) u_calc (
        .tray_level (tray_level),
        .stock      (stock_q),
        .amount     (calc_amt)
    );

`ifdef ABASTECEDOR_ACK_TIMEOUT_EN
    logic fault_q, fault_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault_int = fault_q;
`else
    assign fault_int = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            stock_q <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stock_q <= stock_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stock_d = stock_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
`ifdef ABASTECEDOR_ACK_TIMEOUT_EN
        fault_d = fault_q;
`endif
        // A latched fault blocks any new transfer until clr.
        trigger = enable && !fault_int &&
                  (op_req || (tray_level < cork_t'(MIN_LEVEL)));

        unique case (state_q)
            ST_IDLE: begin
                // A stock load takes priority; a persistent trigger is
                // re-evaluated next cycle against the new stock.
                if (stock_load) begin
                    stock_d = stock_in;
                end else if (trigger) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (!enable || (calc_amt == '0)) begin
                    state_d = ST_IDLE;
                end else begin
                    amt_d   = calc_amt;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Aborting on enable low leaves stock untouched.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (load_ack) begin
                    stock_d = stock_q - amt_q;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
`ifdef ABASTECEDOR_ACK_TIMEOUT_EN
                else if (cnt_q == cnt_t'(TIMEOUT_CYC - 1)) begin
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_SETTLE: begin
                // tray_level is not trusted yet, so triggers are ignored here.
                if (!enable || (cnt_q == cnt_t'(SETTLE_CYC - 1))) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign load_req    = (state_q == ST_REQ);
    assign load_amount = amt_q;
    assign stock_level = stock_q;
    assign sem_estoque = (stock_q == '0);
    assign busy        = (state_q != ST_IDLE);
    assign fault       = fault_int;

endmodule

// File: tb/tb_modulo_abastecedor_rolhas.sv
module tb_modulo_abastecedor_rolhas;

    logic       clk;
    logic       clr;
    logic       enable;
    logic [6:0] tray_level;
    logic       op_req;
    logic       stock_load;
    logic [6:0] stock_in;
    logic       load_ack;
    logic       load_req;
    logic [6:0] load_amount;
    logic [6:0] stock_level;
    logic       sem_estoque;
    logic       busy;
    logic       fault;

    int tests;
    int failed;

    modulo_abastecedor_rolhas dut (
        .clk         (clk),
        .clr         (clr),
        .enable      (enable),
        .tray_level  (tray_level),
        .op_req      (op_req),
        .stock_load  (stock_load),
        .stock_in    (stock_in),
        .load_ack    (load_ack),
        .load_req    (load_req),
        .load_amount (load_amount),
        .stock_level (stock_level),
        .sem_estoque (sem_estoque),
        .busy        (busy),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_stock(input logic [6:0] v);
        stock_load = 1'b1;
        stock_in   = v;
        tick();
        stock_load = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #2;
        tests++;
        if (load_req !== 1'b0) begin failed++; $display("FAIL reset_load_req: got %0d expected 0", load_req); end
        tests++;
        if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0d expected 0", busy); end
        tests++;
        if (fault !== 1'b0) begin failed++; $display("FAIL reset_fault: got %0d expected 0", fault); end
        tests++;
        if (sem_estoque !== 1'b1) begin failed++; $display("FAIL reset_sem_estoque: got %0d expected 1", sem_estoque); end
        tests++;
        if (stock_level !== 7'd0) begin failed++; $display("FAIL reset_stock: got %0d expected 0", stock_level); end
        tests++;
        if (load_amount !== 7'd0) begin failed++; $display("FAIL reset_amount: got %0d expected 0", load_amount); end
        @(negedge clk);
        clr = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        enable     = 1'b1;
        tray_level = 7'd50;
        load_stock(7'd50);
        tests++;
        if (stock_level !== 7'd50) begin failed++; $display("FAIL basic_stock_loaded: got %0d expected 50", stock_level); end
        tray_level = 7'd3;
        tick();
        tests++;
        if (busy !== 1'b1 || load_req !== 1'b0) begin failed++; $display("FAIL basic_calc: busy=%0d load_req=%0d expected busy=1 load_req=0", busy, load_req); end
        tick();
        tests++;
        if (load_req !== 1'b1 || load_amount !== 7'd20) begin failed++; $display("FAIL basic_req: load_req=%0d amount=%0d expected 1/20", load_req, load_amount); end
        load_ack   = 1'b1;
        tray_level = 7'd50;
        tick();
        load_ack = 1'b0;
        tests++;
        if (stock_level !== 7'd30 || load_req !== 1'b0) begin failed++; $display("FAIL basic_after_ack: stock=%0d load_req=%0d expected 30/0", stock_level, load_req); end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            n++;
            tick();
        end
        // busy through the ack cycle plus SETTLE_CYC settle cycles
        tests++;
        if (n + 1 !== 5) begin failed++; $display("FAIL basic_busy_len: got %0d cycles expected 5", n + 1); end
    endtask

    task automatic test_stock_exhaust();
        int reqs;
        load_stock(7'd7);
        tray_level = 7'd0;
        tick();
        tick();
        tests++;
        if (load_req !== 1'b1 || load_amount !== 7'd7) begin failed++; $display("FAIL exhaust_req: load_req=%0d amount=%0d expected 1/7", load_req, load_amount); end
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        tests++;
        if (stock_level !== 7'd0 || sem_estoque !== 1'b1) begin failed++; $display("FAIL exhaust_empty: stock=%0d sem=%0d expected 0/1", stock_level, sem_estoque); end
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (load_req) reqs++;
        end
        tests++;
        if (reqs !== 0) begin failed++; $display("FAIL exhaust_no_req: got %0d req cycles expected 0", reqs); end
        tray_level = 7'd50;
        repeat (3) tick();
    endtask

    task automatic test_room_bound();
        int reqs;
        load_stock(7'd60);
        tray_level = 7'd90;
        op_req     = 1'b1;
        tick();
        op_req = 1'b0;
        tick();
        tests++;
        if (load_req !== 1'b1 || load_amount !== 7'd9) begin failed++; $display("FAIL room_req: load_req=%0d amount=%0d expected 1/9", load_req, load_amount); end
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        tests++;
        if (stock_level !== 7'd51) begin failed++; $display("FAIL room_stock: got %0d expected 51", stock_level); end
        repeat (4) tick();
        tests++;
        if (busy !== 1'b0) begin failed++; $display("FAIL room_settled: busy=%0d expected 0", busy); end
        tray_level = 7'd99;
        op_req     = 1'b1;
        tick();
        op_req = 1'b0;
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (load_req) reqs++;
        end
        tests++;
        if (reqs !== 0 || busy !== 1'b0) begin failed++; $display("FAIL room_full: req cycles=%0d busy=%0d expected 0/0", reqs, busy); end
        tray_level = 7'd50;
    endtask

    task automatic test_hold_and_abort();
        int stable;
        op_req = 1'b1;
        tick();
        op_req = 1'b0;
        tick();
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (load_req === 1'b1 && load_amount === 7'd20) stable++;
            tick();
        end
        tests++;
        if (stable !== 10) begin failed++; $display("FAIL hold_stable: got %0d stable cycles expected 10", stable); end
        load_stock(7'd40);
        tests++;
        if (stock_level !== 7'd51 || load_req !== 1'b1) begin failed++; $display("FAIL hold_load_ignored: stock=%0d load_req=%0d expected 51/1", stock_level, load_req); end
        enable = 1'b0;
        tick();
        tests++;
        if (load_req !== 1'b0 || busy !== 1'b0 || stock_level !== 7'd51) begin failed++; $display("FAIL abort: load_req=%0d busy=%0d stock=%0d expected 0/0/51", load_req, busy, stock_level); end
        enable = 1'b1;
    endtask

    task automatic test_coincident();
        tray_level = 7'd3;
        load_stock(7'd15);
        tests++;
        if (stock_level !== 7'd15 || busy !== 1'b0) begin failed++; $display("FAIL coinc_load: stock=%0d busy=%0d expected 15/0", stock_level, busy); end
        tick();
        tick();
        tests++;
        if (load_req !== 1'b1 || load_amount !== 7'd15) begin failed++; $display("FAIL coinc_req: load_req=%0d amount=%0d expected 1/15", load_req, load_amount); end
        load_ack   = 1'b1;
        tray_level = 7'd50;
        tick();
        load_ack = 1'b0;
        tests++;
        if (stock_level !== 7'd0) begin failed++; $display("FAIL coinc_stock: got %0d expected 0", stock_level); end
        repeat (5) tick();
    endtask

    task automatic test_timeout();
        int n;
        load_stock(7'd30);
        tray_level = 7'd3;
        tick();
        tick();
        tray_level = 7'd50;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!load_req) break;
            n++;
            tick();
        end
`ifdef ABASTECEDOR_ACK_TIMEOUT_EN
        tests++;
        if (n !== 64) begin failed++; $display("FAIL timeout_len: got %0d req cycles expected 64", n); end
        tests++;
        if (fault !== 1'b1 || busy !== 1'b0 || stock_level !== 7'd30) begin failed++; $display("FAIL timeout_fault: fault=%0d busy=%0d stock=%0d expected 1/0/30", fault, busy, stock_level); end
        tray_level = 7'd3;
        op_req     = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            op_req = 1'b0;
            if (busy) n++;
        end
        tests++;
        if (n !== 0) begin failed++; $display("FAIL timeout_blocked: got %0d busy cycles expected 0", n); end
        tray_level = 7'd50;
        clr = 1'b1;
        #2;
        tests++;
        if (fault !== 1'b0) begin failed++; $display("FAIL timeout_clr: fault=%0d expected 0", fault); end
        @(negedge clk);
        clr = 1'b0;
        tick();
`else
        tests++;
        if (n !== 100 || fault !== 1'b0) begin failed++; $display("FAIL no_timeout: req cycles=%0d fault=%0d expected 100/0", n, fault); end
        enable = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || stock_level !== 7'd30 || fault !== 1'b0) begin failed++; $display("FAIL no_timeout_abort: busy=%0d stock=%0d fault=%0d expected 0/30/0", busy, stock_level, fault); end
        enable = 1'b1;
`endif
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        clr        = 1'b1;
        enable     = 1'b0;
        tray_level = 7'd50;
        op_req     = 1'b0;
        stock_load = 1'b0;
        stock_in   = 7'd0;
        load_ack   = 1'b0;
        test_reset();
        test_basic();
        test_stock_exhaust();
        test_room_bound();
        test_hold_and_abort();
        test_coincident();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
